// File: rtl/nss_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nss_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice with flattened carry equations.
module cla4_slice
    import nss_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W:0]   w_c;

    assign w_g = x & y;
    assign w_p = x ^ y;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s    = w_p ^ w_c[NIB_W-1:0];
    assign cout = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle A - B computed as A + ~B + 1, one nibble per clock through a shared CLA slice.
module nibble_serial_subtractor
    import nss_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned NIBBLES = WIDTH / NIB_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_borrow;
    logic             r_overflow;

    logic [NIB_W-1:0] w_x;
    logic [NIB_W-1:0] w_y;
    logic [NIB_W-1:0] w_sum;
    logic             w_cout;

    // Subtrahend nibble is inverted here; the +1 comes from the carry seeded at accept.
    assign w_x = r_a[NIB_W*r_idx +: NIB_W];
    assign w_y = ~r_b[NIB_W*r_idx +: NIB_W];

    cla4_slice u_slice (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_borrow    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_diff     <= '0;
                        r_carry    <= 1'b1;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_diff[NIB_W*r_idx +: NIB_W] <= w_sum;
                    r_carry                      <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_borrow    <= ~w_cout;
                        r_overflow  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1])
                                     & (w_sum[NIB_W-1] ^ r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;

endmodule
